// File: rtl/fifo_pop_stream.sv
// rtl/fifo_pop_stream.sv - FWFT FIFO drain stage with 2-entry skid buffer and delivered-word counter
// fifo_pop depends only on registered occupancy and fifo_empty, so out_ready never reaches the FIFO combinationally.
module fifo_pop_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] delivered_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deq;

  assign fifo_pop      = !rst && !fifo_empty && (state_q != TWO);
  assign out_valid     = (state_q != EMPTY);
  assign deq           = out_valid && out_ready;
  assign out_data      = h_q;
  assign delivered_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    cnt_d   = cnt_q + CNT_W'(deq);
    case (state_q)
      EMPTY: begin
        if (fifo_pop) begin
          h_d     = fifo_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (fifo_pop && deq) begin
          h_d = fifo_data;
        end else if (fifo_pop) begin
          s_d     = fifo_data;
          state_d = TWO;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // S is always the younger word, so it moves up into H on dequeue.
        if (deq) begin
          h_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      h_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/fifo_pop_stream.md
# fifo_pop_stream

Downstream drain stage for `circular_pointer_fifo`. It pops words from the FIFO's first-word-fall-through read side and presents them as a registered valid/ready stream through a 2-entry skid buffer. It sustains one word per cycle and has no combinational path from `out_ready` to `fifo_pop`. It never pops an empty FIFO, so the FIFO's `!empty | !pop` contract holds by construction.

## Interface
- `WIDTH`, 8, data width; must match the feeding FIFO.
- `CNT_W`, 16, width of the delivered-word counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`; holds the head word whenever `fifo_empty`=0.
- `fifo_pop`  out  1  pop strobe to the FIFO.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  WIDTH  output word.
- `delivered_cnt`  out  CNT_W  count of words accepted by the consumer.

## Operation
- Storage:
  - head register H drives `out_data`.
  - skid register S.
  - occupancy `occ` ∈ {0,1,2}; encoded as states EMPTY, ONE, TWO.
- Signal definitions:
  - `out_valid` = (`occ` != 0).
  - `deq` = `out_valid` & `out_ready`.
  - `fifo_pop` = !`rst` & !`fifo_empty` & (`occ` != 2). It depends only on registered state and `fifo_empty`.
- Transitions (`pop` = `fifo_pop`):
  - EMPTY:
    - `pop` → H<=`fifo_data`, ONE.
    - else stay.
  - ONE:
    - `pop`&`deq` → H<=`fifo_data`, ONE.
    - `pop`&!`deq` → S<=`fifo_data`, TWO.
    - !`pop`&`deq` → EMPTY.
    - else hold.
  - TWO:
    - `deq` → H<=S, ONE. No pop occurs in TWO.
    - else hold.
- Ordering: words leave in the order they were popped. H is always older than S.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold.
- `delivered_cnt`:
  - +1 on every `deq`.
  - Wraps modulo 2^CNT_W (all-ones + 1 → 0).
  - No saturation.
- Boundary conditions:
  - `fifo_empty`=1: `fifo_pop`=0 regardless of state.
  - TWO with `fifo_empty`=0: `fifo_pop`=0, and the FIFO retains its word.
  - `out_ready`=1 while EMPTY: no effect, counter unchanged.
  - `rst` mid-operation: buffered words in H/S are discarded. The FIFO is reset by the same `rst`.

## Timing
- Reset values, applied on the edge where `rst`=1:
  - `occ`=EMPTY, `out_valid`=0, `out_data`=0, `delivered_cnt`=0.
  - S=0.
  - `fifo_pop`=0 combinationally for the whole cycle `rst` is high.
- Latency: a word at the FIFO head with `fifo_empty`=0 in cycle N is popped at the end of N and is `out_valid` in N+1.
- Throughput: with `out_ready` held at 1 and the FIFO non-empty, one word is transferred per cycle in steady state ONE.
- Stall recovery:
  - First stalled cycle: ONE→TWO.
  - When `out_ready` returns: TWO→ONE.
  - Next cycle: popping resumes.
- `delivered_cnt` reflects a `deq` on the following cycle (registered).

## Test plan
- Reset and idle: assert `rst` 2 cycles with `fifo_empty`=0 → `fifo_pop`=0, `out_valid`=0, `out_data`=0, `delivered_cnt`=0 throughout; first pop occurs in the cycle after `rst` drops.
- Streaming: FIFO preloaded 0x01..0x08, `out_ready`=1 → `out_valid` from cycle 1, outputs 0x01..0x08 on consecutive cycles, `delivered_cnt`=8, `fifo_pop` never high while `fifo_empty`=1.
- Backpressure:
  - Stimulus: preload 0xA0..0xA3, `out_ready`=0 for 5 cycles, then 1.
  - Exactly 2 pops occur, then `fifo_pop`=0 in TWO.
  - `out_data` holds 0xA0 while stalled.
  - Release delivers 0xA0, 0xA1, 0xA2, 0xA3 in order, with no loss or duplication.
- Random `out_ready`/FIFO fill with scoreboard compare over 1000 words → order and data match, `delivered_cnt`=1000 mod 2^CNT_W.
- Counter wrap: `CNT_W`=4, deliver 17 words → `delivered_cnt`=1.
- Reset in TWO: fill to TWO, assert `rst` 1 cycle → `out_valid`=0 next cycle; no pre-reset word appears after reset.
